// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 DIT FFT butterfly scheduler.
package fft_pkg;

  localparam int FFT_N_LOG2_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FINISH
  } fft_state_e;

  // Twiddle index k = pos << (N_LOG2-1-s); callers truncate to N_LOG2-1 bits.
  function automatic logic [9:0] fft_tw_idx(input logic [3:0] s, input logic [9:0] pos,
                                            input int n_log2);
    int sh;
    sh = n_log2 - 1 - int'(s);
    return pos << sh;
  endfunction

endpackage

// File: rtl/fft_butterfly_scheduler_delay.sv
// fft_addr_delay: LAT-stage shift register carrying {valid, addr_a, addr_b}
// from the read issue point to the write-back point.
module fft_addr_delay #(
  parameter int LAT = 2,
  parameter int AW  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [AW-1:0] addr_b_i,
  output logic          vld_o,
  output logic [AW-1:0] addr_a_o,
  output logic [AW-1:0] addr_b_o
);

  logic          vld_q [LAT];
  logic          vld_d [LAT];
  logic [AW-1:0] a_q   [LAT];
  logic [AW-1:0] a_d   [LAT];
  logic [AW-1:0] b_q   [LAT];
  logic [AW-1:0] b_d   [LAT];

  always_comb begin
    vld_d[0] = vld_i;
    a_d[0]   = addr_a_i;
    b_d[0]   = addr_b_i;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      a_d[i]   = a_q[i-1];
      b_d[i]   = b_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        vld_q[i] <= 1'b0;
        a_q[i]   <= '0;
        b_q[i]   <= '0;
      end
    end else begin
      vld_q <= vld_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  assign vld_o    = vld_q[LAT-1];
  assign addr_a_o = a_q[LAT-1];
  assign addr_b_o = b_q[LAT-1];

endmodule

// File: rtl/fft_butterfly_scheduler.sv
// Radix-2 DIT in-place FFT butterfly sequencer: read addresses, twiddle index, delayed write-back.
// Optional FFT_SCHED_INVERSE_EN adds inverse input and tw_conj output for IFFT scheduling.
//
// state     | meaning
// IDLE      | waiting for start
// ISSUE     | one butterfly read per cycle, j = 0..N/2-1
// DRAIN     | LAT cycles so stage s writes land before stage s+1 reads
// FINISH    | pulse done, drop busy
module fft_butterfly_scheduler
  import fft_pkg::*;
#(
  parameter int N_LOG2 = FFT_N_LOG2_DEF,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
`ifdef FFT_SCHED_INVERSE_EN
  input  logic              inverse,
  output logic              tw_conj,
`endif
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [N_LOG2-2:0] tw_idx,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b
);

  localparam int JW = N_LOG2 - 1;
  localparam int SW = 4;
  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [JW-1:0] J_LAST = JW'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);
  localparam logic [DW-1:0] D_LOAD = DW'(LAT - 1);

  fft_state_e        state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [JW-1:0]     j_q, j_d;
  logic [DW-1:0]     drn_q, drn_d;
  logic              rd_en_q, rd_en_d;
  logic [N_LOG2-1:0] rd_a_q, rd_a_d;
  logic [N_LOG2-1:0] rd_b_q, rd_b_d;
  logic [JW-1:0]     tw_q, tw_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef FFT_SCHED_INVERSE_EN
  logic              inv_q, inv_d;
  logic              conj_q, conj_d;
`endif

  logic [N_LOG2-1:0] span, jx, pos, grp, addr_a, addr_b;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    drn_d   = drn_q;
    rd_en_d = 1'b0;
    rd_a_d  = '0;
    rd_b_d  = '0;
    tw_d    = '0;
    done_d  = 1'b0;
`ifdef FFT_SCHED_INVERSE_EN
    inv_d   = inv_q;
`endif

    span   = N_LOG2'(1) << s_q;
    jx     = N_LOG2'(j_q);
    pos    = jx & (span - N_LOG2'(1));
    grp    = jx >> s_q;
    addr_a = (grp << (s_q + 4'd1)) | pos;
    addr_b = addr_a | span;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          s_d     = '0;
          j_d     = '0;
          state_d = ST_ISSUE;
`ifdef FFT_SCHED_INVERSE_EN
          inv_d   = inverse;
`endif
        end
      end
      ST_ISSUE: begin
        rd_en_d = 1'b1;
        rd_a_d  = addr_a;
        rd_b_d  = addr_b;
        tw_d    = JW'(fft_tw_idx(s_q, 10'(pos), N_LOG2));
        if (j_q == J_LAST) begin
          j_d     = '0;
          drn_d   = D_LOAD;
          state_d = ST_DRAIN;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drn_q == '0) begin
          if (s_q == S_LAST) begin
            state_d = ST_FINISH;
          end else begin
            s_d     = s_q + 1'b1;
            j_d     = '0;
            state_d = ST_ISSUE;
          end
        end else begin
          drn_d = drn_q - 1'b1;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
`ifdef FFT_SCHED_INVERSE_EN
    conj_d = inv_q & rd_en_d;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      j_q     <= '0;
      drn_q   <= '0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
      drn_q   <= drn_d;
      rd_en_q <= rd_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      tw_q    <= tw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef FFT_SCHED_INVERSE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_q  <= 1'b0;
      conj_q <= 1'b0;
    end else begin
      inv_q  <= inv_d;
      conj_q <= conj_d;
    end
  end

  assign tw_conj = conj_q;
`endif

  // Write-back follows the registered read strobe by exactly LAT cycles.
  fft_addr_delay #(
    .LAT (LAT),
    .AW  (N_LOG2)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .vld_i    (rd_en_q),
    .addr_a_i (rd_a_q),
    .addr_b_i (rd_b_q),
    .vld_o    (wr_en),
    .addr_a_o (wr_addr_a),
    .addr_b_o (wr_addr_b)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign tw_idx    = tw_q;

endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// Scoreboard bench for fft_butterfly_scheduler at N_LOG2=3, LAT=2.
module tb_fft_butterfly_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, rd_en, wr_en;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_idx;
`ifdef FFT_SCHED_INVERSE_EN
  logic       inverse;
  logic       tw_conj;
`endif

  fft_butterfly_scheduler #(.N_LOG2(3), .LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef FFT_SCHED_INVERSE_EN
    .inverse   (inverse),
    .tw_conj   (tw_conj),
`endif
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_idx    (tw_idx),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int k;
    int conj;
    int cyc;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Hand-computed (a,b,k) order for N=8: stages 0, 1, 2.
  int EA [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int EB [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int EK [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT presents a strobe.
  always @(negedge clk) begin
    ev_t e;
    int  d;
    if (rd_en) begin
      if (rd_q.size() == 0) chk("rd_unexpected", int'(rd_en), 0);
      else begin
        e = rd_q.pop_front();
        chk("rd_cycle", cyc, e.cyc);
        chk("rd_addr_a", int'(rd_addr_a), e.a);
        chk("rd_addr_b", int'(rd_addr_b), e.b);
        chk("tw_idx", int'(tw_idx), e.k);
`ifdef FFT_SCHED_INVERSE_EN
        chk("tw_conj", int'(tw_conj), e.conj);
`endif
      end
    end
`ifdef FFT_SCHED_INVERSE_EN
    else chk("tw_conj_idle", int'(tw_conj), 0);
`endif
    if (wr_en) begin
      if (wr_q.size() == 0) chk("wr_unexpected", int'(wr_en), 0);
      else begin
        e = wr_q.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_addr_a", int'(wr_addr_a), e.a);
        chk("wr_addr_b", int'(wr_addr_b), e.b);
      end
    end
    if (done) begin
      if (done_q.size() == 0) chk("done_unexpected", int'(done), 0);
      else begin
        d = done_q.pop_front();
        chk("done_cycle", cyc, d);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic push_run(input int t0, input int conj);
    ev_t e;
    for (int i = 0; i < 12; i++) begin
      e.a    = EA[i];
      e.b    = EB[i];
      e.k    = EK[i];
      e.conj = conj;
      e.cyc  = t0 + 1 + (i / 4) * 6 + (i % 4);
      rd_q.push_back(e);
      e.cyc  = e.cyc + 2;
      wr_q.push_back(e);
    end
    done_q.push_back(t0 + 19);
  endtask

  task automatic wait_drained(input int budget, input bit toggle);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
`ifdef FFT_SCHED_INVERSE_EN
      if (toggle) inverse = ~inverse;
`endif
      if (rd_q.size() + wr_q.size() + done_q.size() == 0) break;
    end
    chk("drained", rd_q.size() + wr_q.size() + done_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_addr"}, int'({rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, tw_idx}), 0);
  endtask

  initial begin
    int t0;
    rst   = 1'b1;
    start = 1'b0;
`ifdef FFT_SCHED_INVERSE_EN
    inverse = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single forward run with a one-cycle start pulse.
    start = 1'b1;
    t0 = cyc + 1;
    push_run(t0, 0);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    wait_drained(60, 1'b0);
    repeat (3) @(negedge clk);

    // start held across a whole run: exactly two back-to-back runs.
    start = 1'b1;
    t0 = cyc + 1;
    push_run(t0, 0);
    push_run(t0 + 20, 0);
    for (int n = 0; n < 40 && cyc < t0 + 20; n++) @(negedge clk);
    chk("held_start_cycle", cyc, t0 + 20);
    start = 1'b0;
    wait_drained(60, 1'b0);
    repeat (3) @(negedge clk);

    // Reset in the middle of stage 0.
    start = 1'b1;
    t0 = cyc + 1;
    push_run(t0, 0);
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 10 && cyc < t0 + 3; n++) @(negedge clk);
    #2 rst = 1'b1;
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    #1 check_all_zero("midrun_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_after_reset", int'(busy), 0);

    // Final run; with the inverse option, inverse=1 at start and toggled during the run.
`ifdef FFT_SCHED_INVERSE_EN
    inverse = 1'b1;
    start = 1'b1;
    t0 = cyc + 1;
    push_run(t0, 1);
`else
    start = 1'b1;
    t0 = cyc + 1;
    push_run(t0, 0);
`endif
    @(negedge clk);
    start = 1'b0;
    wait_drained(60, 1'b1);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
